// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module  : fft_bitrev_reorder
// Brief   : Ping-pong register buffer that turns bit-reversed FFT output
//           frames into natural index order, with valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
    parameter int N_LOG2 = 3,
    parameter int DATA_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_r,
    input  logic signed [DATA_W-1:0] in_i,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_r,
    output logic signed [DATA_W-1:0] out_i,
    output logic                     out_last,
    output logic                     frame_err
);

    localparam int                N       = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] CNT_MAX = N_LOG2'(N - 1);

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] rev;
        for (int b = 0; b < N_LOG2; b++) begin
            rev[b] = v[N_LOG2-1-b];
        end
        return rev;
    endfunction

    logic signed [DATA_W-1:0] mem_r_q [2][N];
    logic signed [DATA_W-1:0] mem_i_q [2][N];

    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0] wr_cnt_q,  wr_cnt_d;
    logic [N_LOG2-1:0] rd_cnt_q,  rd_cnt_d;
    logic [1:0]        full_q,    full_d;
    logic              frame_err_q, frame_err_d;

    logic              wr_accept;
    logic              rd_xfer;
    logic              wr_done;
    logic              rd_done;
    logic [N_LOG2-1:0] wr_addr;

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_r     = mem_r_q[rd_bank_q][rd_cnt_q];
    assign out_i     = mem_i_q[rd_bank_q][rd_cnt_q];
    assign out_last  = out_valid & (rd_cnt_q == CNT_MAX);
    assign frame_err = frame_err_q;

    assign wr_accept = in_valid & in_ready;
    assign rd_xfer   = out_valid & out_ready;
    assign wr_done   = wr_accept & (wr_cnt_q == CNT_MAX);
    assign rd_done   = rd_xfer & (rd_cnt_q == CNT_MAX);
    assign wr_addr   = bitrev(wr_cnt_q);

    // Counters wrap naturally at N; a completed write and a completed read
    // always touch different banks, so both full-flag updates may apply.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        frame_err_d = frame_err_q;
        if (wr_accept) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (in_last != (wr_cnt_q == CNT_MAX)) begin
                frame_err_d = 1'b1;
            end
        end
        if (wr_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (rd_xfer) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int e = 0; e < N; e++) begin
                    mem_r_q[b][e] <= '0;
                    mem_i_q[b][e] <= '0;
                end
            end
        end else if (wr_accept) begin
            mem_r_q[wr_bank_q][wr_addr] <= in_r;
            mem_i_q[wr_bank_q][wr_addr] <= in_i;
        end
    end

endmodule
`default_nettype wire

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output-side reorder buffer for the radix-2 FFT datapath. It consumes complex 12-bit butterfly results, which arrive in bit-reversed index order.
- It re-emits each frame in natural index order 0..N-1.
- Uses a two-bank ping-pong register buffer with valid/ready handshakes on both sides, so one frame can be written while the previous one is read out.

Parameters:
- N_LOG2, 3, log2 of FFT frame length; N = 2**N_LOG2 (8 by default).
- DATA_W, 12, signed width of each real/imag component. Matches the butterfly Q-format; no arithmetic is performed here.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input sample valid.
- in_ready  output  1  buffer can accept input sample.
- in_r  input  DATA_W  signed real part, bit-reversed order.
- in_i  input  DATA_W  signed imag part.
- in_last  input  1  upstream marks last sample of frame.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts output sample.
- out_r  output  DATA_W  signed real part, natural order.
- out_i  output  DATA_W  signed imag part.
- out_last  output  1  high with sample index N-1 of each output frame.
- frame_err  output  1  sticky: in_last misaligned with internal frame count.

Behaviour:
Storage and state:
- Storage: mem[2][N] of {r,i}, all registers; no RAM macro.
- State regs: wr_bank, wr_cnt[N_LOG2-1:0], rd_bank, rd_cnt[N_LOG2-1:0], full[1:0], frame_err.

Reset (rst_n low, async):
- All state regs go to 0 and mem entries go to 0.
- Outputs during reset: in_ready=1, out_valid=0, out_r=0, out_i=0, out_last=0, frame_err=0.
- Reset mid-frame discards all partially written and partially read data. No sample is emitted after reset release until a new full frame has been written.

Write side:
- in_ready = !full[wr_bank], combinational.
- Accept = in_valid & in_ready.
- On accept: mem[wr_bank][bitrev(wr_cnt)] <= {in_r,in_i}. bitrev reverses the N_LOG2 bits, e.g. N=8: 1->4, 3->6.
- On accept, wr_cnt++. On the accept with wr_cnt==N-1: wr_cnt<=0, full[wr_bank]<=1, wr_bank toggles.
- frame_err set (sticky until reset) on any accept where in_last != (wr_cnt==N-1). Counting continues from the internal counter regardless; no resync.

Read side:
- out_valid = full[rd_bank].
- out_r/out_i = mem[rd_bank][rd_cnt] via combinational mux from registers.
- out_last = out_valid & (rd_cnt==N-1).
- Transfer = out_valid & out_ready.
- On transfer: rd_cnt++. On the transfer with rd_cnt==N-1: rd_cnt<=0, full[rd_bank]<=0, rd_bank toggles.
- While out_valid & !out_ready, out_r/out_i/out_last hold stable.

Latency and throughput:
- out_valid rises the cycle after the accept of the frame's Nth sample.
- Sustained throughput is 1 sample/clk in and out when both sides stream.

Boundary conditions:
- Both banks full: in_ready=0, input stalls.
- Write-set and read-clear in the same cycle always target different banks; both updates apply.
- A write to bank B cannot occur while B is full, so read data is never overwritten.
- wr_cnt and rd_cnt wrap modulo N; the bank bits wrap modulo 2.

Test Plan:
- Single frame, N=8: send in_r = 0,400,200,600,100,500,300,700 with in_i = negation and in_last on the 8th. Required: out_r = 0,100,...,700 and out_i = 0,-100,...,-700. out_valid rises the cycle after the 8th accept; out_last only on 700. frame_err=0.
- Back-to-back streaming: 4 frames with in_valid=1 and out_ready=1 continuously. Required: in_ready never drops after reset; outputs are continuous at 1/clk after the initial 8-cycle fill, in natural order per frame.
- Backpressure: out_ready=0 while streaming. Required: after exactly 16 accepts in_ready=0 and out_valid=1 holding sample 0 of frame 0. Raising out_ready drains in order with no loss or duplication.
- Random handshake: randomize in_valid and out_ready at 50% over 20 frames with extreme values ±2047/-2048. Required: output matches the bit-reverse permutation of input bit-exactly, sign preserved.
- Misaligned in_last: assert in_last on the 5th sample. Required: frame_err=1 the next cycle and stays 1. The frame still completes after 8 samples.
- Reset mid-operation: assert rst_n=0 after 5 samples written and 3 samples read of the previous frame. Required: out_valid=0, in_ready=1 and outputs 0 immediately. After release, the first output appears only after 8 new accepts.
